// File: rtl/dbg_vector_io.sv
// Debug vector loader: narrow chunk writes into a shadow register, atomic commit
// to vec_out on a rising set, plus held observation capture with slice display.
module dbg_vector_io #(
    parameter int  CHUNK_W = 10,
    parameter int  VEC_W   = 160,
    parameter int  OBS_W   = 64,
    parameter int  DISP_W  = 4,
    localparam int NCHUNK  = VEC_W / CHUNK_W,
    localparam int NSLICE  = OBS_W / DISP_W,
    localparam int IDX_W   = $clog2(NCHUNK > NSLICE ? NCHUNK : NSLICE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [IDX_W-1:0]   sel,
    input  logic [CHUNK_W-1:0] din,
    input  logic               din_valid,
    input  logic               set,
    input  logic [OBS_W-1:0]   obs_data,
    input  logic               obs_valid,
    output logic [VEC_W-1:0]   vec_out,
    output logic               commit_pulse,
    output logic [IDX_W-1:0]   stream_ptr,
    output logic               stream_full,
    output logic               overflow,
    output logic [DISP_W-1:0]  disp
);

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

    localparam logic [IDX_W:0]   NCHUNK_L = (IDX_W+1)'(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t             state_q, state_d, cur_state;
    logic [IDX_W-1:0]   ptr_q, ptr_d, cur_ptr, wr_idx;
    logic [VEC_W-1:0]   shadow;
    logic [OBS_W-1:0]   obs_reg;
    logic               set_q, mode_q, ovf_d, wr_en, commit, mode_chg;

    assign stream_ptr  = ptr_q;
    assign stream_full = (state_q == S_FULL);

    always_comb begin
        commit    = set && !set_q;
        mode_chg  = (mode != mode_q);
        // A mode switch restarts the stream before any write in the same cycle
        cur_state = mode_chg ? S_EMPTY : state_q;
        cur_ptr   = mode_chg ? '0 : ptr_q;
        state_d   = cur_state;
        ptr_d     = cur_ptr;
        ovf_d     = overflow;
        wr_en     = 1'b0;
        wr_idx    = sel;
        if (din_valid) begin
            if (!mode) begin
                wr_en  = ({1'b0, sel} < NCHUNK_L);
                wr_idx = sel;
            end else if (cur_state == S_FULL) begin
                ovf_d = 1'b1;
            end else begin
                wr_en  = 1'b1;
                wr_idx = cur_ptr;
                if (cur_ptr == LAST_IDX) begin
                    state_d = S_FULL;
                end else begin
                    state_d = S_PARTIAL;
                    ptr_d   = cur_ptr + 1'b1;
                end
            end
        end
        // Commit wins over a concurrent stream write: the chunk lands but the pointer restarts
        if (commit) begin
            state_d = S_EMPTY;
            ptr_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_EMPTY;
            ptr_q        <= '0;
            overflow     <= 1'b0;
            set_q        <= 1'b1;
            mode_q       <= 1'b0;
            commit_pulse <= 1'b0;
            vec_out      <= '0;
            shadow       <= '0;
            obs_reg      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            overflow     <= ovf_d;
            set_q        <= set;
            mode_q       <= mode;
            commit_pulse <= commit;
            if (commit)
                vec_out <= shadow;
            for (int i = 0; i < NCHUNK; i++)
                if (wr_en && wr_idx == IDX_W'(i))
                    shadow[i*CHUNK_W +: CHUNK_W] <= din;
            if (obs_valid)
                obs_reg <= obs_data;
        end
    end

    always_comb begin
        disp = '0;
        for (int i = 0; i < NSLICE; i++)
            if (sel == IDX_W'(i))
                disp = obs_reg[i*DISP_W +: DISP_W];
    end

endmodule

// File: tb/tb_dbg_vector_io.sv
// Directed bench for dbg_vector_io: indexed/stream load, commit edge rules,
// overflow, reset behaviour and observation slice display.
module tb_dbg_vector_io;
    logic         clk = 1'b0;
    logic         reset;
    logic         mode;
    logic [3:0]   sel;
    logic [9:0]   din;
    logic         din_valid;
    logic         set;
    logic [63:0]  obs_data;
    logic         obs_valid;
    logic [159:0] vec_out;
    logic         commit_pulse;
    logic [3:0]   stream_ptr;
    logic         stream_full;
    logic         overflow;
    logic [3:0]   disp;

    logic [159:0] vec_out2;
    logic         commit_pulse2, stream_full2, overflow2;
    logic [3:0]   stream_ptr2, disp2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbg_vector_io dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel), .din(din),
        .din_valid(din_valid), .set(set), .obs_data(obs_data), .obs_valid(obs_valid),
        .vec_out(vec_out), .commit_pulse(commit_pulse), .stream_ptr(stream_ptr),
        .stream_full(stream_full), .overflow(overflow), .disp(disp)
    );

    // Narrow observation instance for out-of-range slice select
    dbg_vector_io #(.OBS_W(32)) dut32 (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel), .din(din),
        .din_valid(din_valid), .set(set), .obs_data(obs_data[31:0]), .obs_valid(obs_valid),
        .vec_out(vec_out2), .commit_pulse(commit_pulse2), .stream_ptr(stream_ptr2),
        .stream_full(stream_full2), .overflow(overflow2), .disp(disp2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int pulses;
        reset = 1'b1; mode = 1'b0; sel = '0; din = '0; din_valid = 1'b0;
        set = 1'b1; obs_data = '0; obs_valid = 1'b0;
        tick(); tick();
        total++; if (vec_out !== '0) begin bad++; $display("FAIL reset_vec got=%h exp=0", vec_out); end
        total++; if ({commit_pulse, stream_ptr, stream_full, overflow, disp} !== 11'd0) begin
            bad++; $display("FAIL reset_flags got=%b exp=0", {commit_pulse, stream_ptr, stream_full, overflow, disp});
        end
        // set held high across release must not commit
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (commit_pulse) pulses++; end
        total++; if (pulses != 0) begin bad++; $display("FAIL reset_set_high pulses=%0d exp=0", pulses); end
        set = 1'b0; tick();
        set = 1'b1; tick();
        total++; if (commit_pulse !== 1'b1) begin bad++; $display("FAIL reset_then_edge got=%b exp=1", commit_pulse); end
        set = 1'b0; tick();
    endtask

    task automatic test_indexed();
        logic [159:0] exp_v;
        exp_v = '0;
        exp_v[159:150] = 10'h3FF;
        mode = 1'b0; sel = 4'd15; din = 10'h3FF; din_valid = 1'b1; tick();
        din_valid = 1'b0;
        total++; if (vec_out !== '0) begin bad++; $display("FAIL idx_no_early got=%h exp=0", vec_out); end
        set = 1'b1; tick();
        total++; if (commit_pulse !== 1'b1) begin bad++; $display("FAIL idx_pulse got=%b exp=1", commit_pulse); end
        total++; if (vec_out !== exp_v) begin bad++; $display("FAIL idx_vec got=%h exp=%h", vec_out, exp_v); end
        set = 1'b0; tick();
        total++; if (commit_pulse !== 1'b0) begin bad++; $display("FAIL idx_pulse_width got=%b exp=0", commit_pulse); end
    endtask

    task automatic test_set_hold();
        int pulses = 0;
        set = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); if (commit_pulse) pulses++; end
        set = 1'b0; tick();
        if (commit_pulse) pulses++;
        total++; if (pulses != 1) begin bad++; $display("FAIL set_hold pulses=%0d exp=1", pulses); end
    endtask

    task automatic test_stream();
        logic [159:0] exp_v;
        mode = 1'b1; tick();
        total++; if (stream_ptr !== 4'd0) begin bad++; $display("FAIL str_start ptr=%0d exp=0", stream_ptr); end
        for (int k = 0; k < 16; k++) begin
            din = 10'(k); din_valid = 1'b1; tick();
            exp_v[k*10 +: 10] = 10'(k);
            if (k == 4) begin
                total++; if (stream_ptr !== 4'd5 || stream_full !== 1'b0) begin
                    bad++; $display("FAIL str_mid ptr=%0d full=%b exp=5,0", stream_ptr, stream_full);
                end
            end
        end
        total++; if (stream_full !== 1'b1 || stream_ptr !== 4'd15 || overflow !== 1'b0) begin
            bad++; $display("FAIL str_full full=%b ptr=%0d ovf=%b exp=1,15,0", stream_full, stream_ptr, overflow);
        end
        din = 10'h3FF; tick();
        din_valid = 1'b0;
        total++; if (overflow !== 1'b1 || stream_ptr !== 4'd15) begin
            bad++; $display("FAIL str_ovf ovf=%b ptr=%0d exp=1,15", overflow, stream_ptr);
        end
        set = 1'b1; tick();
        total++; if (overflow !== 1'b0 || stream_ptr !== 4'd0 || stream_full !== 1'b0 || commit_pulse !== 1'b1) begin
            bad++; $display("FAIL str_commit ovf=%b ptr=%0d full=%b pulse=%b exp=0,0,0,1", overflow, stream_ptr, stream_full, commit_pulse);
        end
        total++; if (vec_out !== exp_v) begin bad++; $display("FAIL str_vec got=%h exp=%h", vec_out, exp_v); end
        set = 1'b0; tick();
        // mode switch restarts the pointer
        din_valid = 1'b1; tick(); tick(); tick();
        din_valid = 1'b0;
        total++; if (stream_ptr !== 4'd3) begin bad++; $display("FAIL str_ptr3 got=%0d exp=3", stream_ptr); end
        mode = 1'b0; tick();
        total++; if (stream_ptr !== 4'd0) begin bad++; $display("FAIL str_mode_chg got=%0d exp=0", stream_ptr); end
        // stream write and commit on one edge
        mode = 1'b1; tick();
        din_valid = 1'b1; tick();
        set = 1'b1; tick();
        din_valid = 1'b0; set = 1'b0;
        total++; if (stream_ptr !== 4'd0 || stream_full !== 1'b0) begin
            bad++; $display("FAIL str_wr_commit ptr=%0d full=%b exp=0,0", stream_ptr, stream_full);
        end
        tick();
    endtask

    task automatic test_write_commit_same();
        mode = 1'b0; tick();
        sel = 4'd0; din = 10'h0AA; din_valid = 1'b1; tick();
        din = 10'h155; set = 1'b1; tick();
        din_valid = 1'b0; set = 1'b0;
        total++; if (vec_out[9:0] !== 10'h0AA) begin bad++; $display("FAIL same_edge_old got=%h exp=0aa", vec_out[9:0]); end
        tick();
        set = 1'b1; tick();
        set = 1'b0;
        total++; if (vec_out[9:0] !== 10'h155) begin bad++; $display("FAIL same_edge_new got=%h exp=155", vec_out[9:0]); end
        tick();
    endtask

    task automatic test_obs();
        obs_data = 64'h0123_4567_89AB_CDEF; obs_valid = 1'b1; tick();
        obs_valid = 1'b0; obs_data = 64'hFEDC_BA98_7654_3210; tick();
        sel = 4'd0; #1;
        total++; if (disp !== 4'hF) begin bad++; $display("FAIL obs_sel0 got=%h exp=f", disp); end
        sel = 4'd15; #1;
        total++; if (disp !== 4'h0) begin bad++; $display("FAIL obs_sel15 got=%h exp=0", disp); end
        sel = 4'd5; #1;
        total++; if (disp !== 4'hA) begin bad++; $display("FAIL obs_sel5 got=%h exp=a", disp); end
        sel = 4'd7; #1;
        total++; if (disp2 !== 4'h8) begin bad++; $display("FAIL obs32_sel7 got=%h exp=8", disp2); end
        sel = 4'd8; #1;
        total++; if (disp2 !== 4'h0) begin bad++; $display("FAIL obs32_sel8 got=%h exp=0", disp2); end
        sel = 4'd14; #1;
        total++; if (disp2 !== 4'h0) begin bad++; $display("FAIL obs32_sel14 got=%h exp=0", disp2); end
    endtask

    task automatic test_reset_mid_load();
        mode = 1'b1; tick();
        din_valid = 1'b1; tick(); tick();
        din_valid = 1'b0;
        reset = 1'b1; #1;
        total++; if (stream_ptr !== 4'd0 || vec_out !== '0 || disp !== 4'h0) begin
            bad++; $display("FAIL reset_async ptr=%0d vec=%h disp=%h exp=0", stream_ptr, vec_out, disp);
        end
        tick();
        reset = 1'b0; tick();
        total++; if (commit_pulse !== 1'b0 || vec_out !== '0) begin
            bad++; $display("FAIL reset_after pulse=%b vec=%h exp=0", commit_pulse, vec_out);
        end
    endtask

    initial begin
        test_reset();
        test_indexed();
        test_set_hold();
        test_stream();
        test_write_commit_same();
        test_obs();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dbg_vector_io.md
# dbg_vector_io

Parametrised board-level debug I/O block that loads a wide stimulus vector in narrow chunks, commits it atomically to the core, and captures core observation data for nibble-wise display. It sits between the FPGA switch/button pins and the CPU pipeline test harness. It generalises the fixed 160-bit / 10-bit-chunk loader with configurable widths, a streaming auto-increment mode, edge-triggered commit, overflow tracking and held observation capture.

## Interface
Parameters:
- CHUNK_W, 10, bits written per load
- VEC_W, 160, committed vector width; must be a multiple of CHUNK_W
- OBS_W, 64, observed data width; must be a multiple of DISP_W
- DISP_W, 4, display slice width
- IDX_W, derived, $clog2(max(VEC_W/CHUNK_W, OBS_W/DISP_W))

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- mode  in  1  0 = indexed load, 1 = stream load
- sel  in  IDX_W  chunk index (indexed mode) and display slice select (both modes)
- din  in  CHUNK_W  load data
- din_valid  in  1  load strobe
- set  in  1  level; commit on rising edge
- obs_data  in  OBS_W  core observation data
- obs_valid  in  1  capture strobe for obs_data
- vec_out  out  VEC_W  committed vector
- commit_pulse  out  1  high one cycle per commit
- stream_ptr  out  IDX_W  next chunk index in stream mode
- stream_full  out  1  all chunks loaded in stream mode
- overflow  out  1  sticky: stream write attempted while full
- disp  out  DISP_W  selected slice of captured observation

## Operation
- Shadow register (VEC_W) holds loaded chunks; vec_out is a separate register updated only on commit.
- Indexed mode: din_valid writes din into shadow[sel*CHUNK_W +: CHUNK_W]; sel >= VEC_W/CHUNK_W -> write ignored.
- Stream mode: FSM EMPTY -> PARTIAL -> FULL. din_valid writes chunk stream_ptr, increments ptr; EMPTY->PARTIAL on first write; PARTIAL->FULL when last chunk written (ptr stays at last index). In FULL, din_valid ignored, overflow set.
- Any mode change (mode differs from previous cycle) -> ptr = 0, FSM = EMPTY; shadow untouched.
- Commit: set_q registers set; commit when set && !set_q. vec_out <= shadow, commit_pulse = 1, ptr = 0, FSM = EMPTY, overflow cleared. Shadow retained.
- Write and commit same edge: vec_out takes pre-write shadow; write lands in shadow; stream ptr becomes 0 (write counted then discarded from ptr), FSM = EMPTY.
- Observation: obs register captures obs_data on obs_valid, holds otherwise.
- disp = obs_reg[sel*DISP_W +: DISP_W], combinational from obs_reg; sel >= OBS_W/DISP_W -> disp = 0.

## Timing
- Reset (async assert, sync-safe release): shadow, vec_out, obs_reg, ptr, overflow, commit_pulse = 0; FSM = EMPTY; stream_full = 0; set_q = 1 (set held high through reset causes no commit until it falls and rises).
- Load latency: 1 cycle (shadow visible internally next cycle; not on vec_out until commit).
- Commit latency: vec_out and commit_pulse valid the cycle after the edge sampling set=1 with set_q=0; commit_pulse exactly 1 cycle wide regardless of set hold time.
- stream_full, stream_ptr, overflow registered, update 1 cycle after the causing write.
- Observation capture 1 cycle; disp changes combinationally with sel.
- Reset mid-load or mid-commit: all state cleared immediately, no partial commit.

## Test plan
- Indexed: defaults, write din=0x3FF to sel=15, pulse set -> vec_out[159:150]=0x3FF, all other bits 0, commit_pulse high 1 cycle.
- Stream: 16 writes din=k (k=0..15) -> stream_full=1 after 16th, ptr=15; 17th write -> overflow=1, shadow unchanged; commit -> overflow=0, ptr=0, vec_out chunk k = k.
- Set held high 10 cycles -> exactly one commit_pulse; set high across reset release -> no commit until set low then high.
- Write chunk 0=0x155 and set rising same edge, chunk 0 previously 0x0AA -> vec_out[9:0]=0x0AA; next commit -> 0x155.
- obs_data=0x0123_4567_89AB_CDEF with obs_valid 1 cycle, then obs_data changes with obs_valid=0 -> sel=0 disp=0xF, sel=15 disp=0x0; sel out of range with OBS_W=32 -> disp=0.
